management_wb_bridge: RTL and testbench

- Downstream stage of the JTAG debug TAP. It consumes the TAP's single-cycle management request pulses (enable, writeEnable, byteSelect, address, writeData).
- Each accepted pulse becomes one classic Wishbone B4 master cycle on the core's system bus, with a bounded wait for ack, err or timeout.
- It returns held read data plus busy and status flags that the TAP polls.
- One request is outstanding at a time; there is no queue.

---
 rtl/management_wb_bridge_pkg.sv | 17 +
 rtl/management_wb_bridge_if.sv | 24 ++
 rtl/management_wb_bridge.sv | 144 ++++++++++++++
 tb/tb_management_wb_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/management_wb_bridge_pkg.sv
// Shared definitions for the management-to-Wishbone bridge: FSM states,
// completion status codes and the byte-select default.
package management_wb_bridge_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [1:0] STATUS_OK        = 2'd0;
  localparam logic [1:0] STATUS_BUS_ERROR = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT   = 2'd2;

  // A byteSelect of zero from the TAP means a full-word access.
  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/management_wb_bridge_if.sv
// Classic Wishbone B4 bus signals between the bridge (master) and the system bus (slave).
interface management_wb_bridge_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
    input  wb_data_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
    output wb_data_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/management_wb_bridge.sv
// Turns single-cycle TAP management request pulses into one Wishbone cycle each,
// with bounded wait for ack/err, held read data and sticky status for polling.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no cycle on the bus; a management_enable pulse starts one
// ST_BUS   | cyc/stb high, waiting for ack, err or the timeout count
module management_wb_bridge
  import management_wb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] ERROR_READ_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        management_enable,
  input  logic        management_writeEnable,
  input  logic [3:0]  management_byteSelect,
  input  logic [19:0] management_address,
  input  logic [31:0] management_writeData,
  output logic [31:0] management_readData,
  output logic        management_busy,
  output logic [1:0]  management_status,
  output logic        management_dropped,
  input  logic        management_statusClear,
  management_wb_bridge_if.master wb
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0] ADR_RESET = {BASE_ADDRESS[31:22], 22'b0};

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             cyc, cycNext;
  logic             we, weNext;
  logic [3:0]       sel, selNext;
  logic [31:0]      adr, adrNext;
  logic [31:0]      dataOut, dataOutNext;
  logic [31:0]      readData, readDataNext;
  logic [1:0]       status, statusNext;
  logic             dropped, droppedNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cyc      <= 1'b0;
      we       <= 1'b0;
      sel      <= 4'h0;
      adr      <= ADR_RESET;
      dataOut  <= 32'h0;
      readData <= 32'h0;
      status   <= STATUS_OK;
      dropped  <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      cyc      <= cycNext;
      we       <= weNext;
      sel      <= selNext;
      adr      <= adrNext;
      dataOut  <= dataOutNext;
      readData <= readDataNext;
      status   <= statusNext;
      dropped  <= droppedNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    cycNext      = cyc;
    weNext       = we;
    selNext      = sel;
    adrNext      = adr;
    dataOutNext  = dataOut;
    readDataNext = readData;
    statusNext   = status;
    droppedNext  = dropped;

    // Clear is applied first so a same-edge completion or drop overrides it.
    if (management_statusClear) begin
      droppedNext = 1'b0;
      statusNext  = STATUS_OK;
    end

    case (state)
      ST_IDLE: begin
        if (management_enable) begin
          stateNext   = ST_BUS;
          cntNext     = '0;
          cycNext     = 1'b1;
          weNext      = management_writeEnable;
          selNext     = (management_byteSelect == 4'h0) ? SEL_ALL : management_byteSelect;
          adrNext     = {BASE_ADDRESS[31:22], management_address, 2'b00};
          dataOutNext = management_writeEnable ? management_writeData : 32'h0;
        end
      end
      ST_BUS: begin
        if (management_enable) begin
          droppedNext = 1'b1;
        end
        if (wb.wb_err_i) begin
          stateNext  = ST_IDLE;
          cycNext    = 1'b0;
          statusNext = STATUS_BUS_ERROR;
          if (!we) readDataNext = ERROR_READ_DATA;
        end else if (wb.wb_ack_i) begin
          stateNext  = ST_IDLE;
          cycNext    = 1'b0;
          statusNext = STATUS_OK;
          if (!we) readDataNext = wb.wb_data_i;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LIMIT)) begin
          stateNext  = ST_IDLE;
          cycNext    = 1'b0;
          statusNext = STATUS_TIMEOUT;
          if (!we) readDataNext = ERROR_READ_DATA;
        end else if (cnt != CNT_MAX) begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cycNext   = 1'b0;
      end
    endcase
  end

  assign wb.wb_cyc_o  = cyc;
  assign wb.wb_stb_o  = cyc;
  assign wb.wb_we_o   = we;
  assign wb.wb_sel_o  = sel;
  assign wb.wb_adr_o  = adr;
  assign wb.wb_data_o = dataOut;

  assign management_readData = readData;
  assign management_busy     = (state == ST_BUS);
  assign management_status   = status;
  assign management_dropped  = dropped;

endmodule

// File: tb/tb_management_wb_bridge.sv
// Scoreboarded bench for management_wb_bridge: reads, writes, timeout, err, drop/clear, reset.
module tb_management_wb_bridge;
  import management_wb_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        management_enable = 1'b0;
  logic        management_writeEnable = 1'b0;
  logic [3:0]  management_byteSelect = 4'h0;
  logic [19:0] management_address = 20'h0;
  logic [31:0] management_writeData = 32'h0;
  logic [31:0] management_readData;
  logic        management_busy;
  logic [1:0]  management_status;
  logic        management_dropped;
  logic        management_statusClear = 1'b0;

  management_wb_bridge_if wb ();

  management_wb_bridge #(
    .BASE_ADDRESS    (32'h3000_0000),
    .TIMEOUT_CYCLES  (4),
    .ERROR_READ_DATA (32'hFFFF_FFFF)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .management_enable      (management_enable),
    .management_writeEnable (management_writeEnable),
    .management_byteSelect  (management_byteSelect),
    .management_address     (management_address),
    .management_writeData   (management_writeData),
    .management_readData    (management_readData),
    .management_busy        (management_busy),
    .management_status      (management_status),
    .management_dropped     (management_dropped),
    .management_statusClear (management_statusClear),
    .wb                     (wb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [1:0]  st;
  } exp_t;

  exp_t expQ[$];
  int checkCount = 0;
  int passCount = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCount, checkCount);
    $fatal(1);
  end

  // Pulse a request for one edge; returns at request edge + 1ns.
  task automatic issue(input logic isWrite, input logic [3:0] bs, input logic [19:0] adr,
                       input logic [31:0] data);
    management_enable      = 1'b1;
    management_writeEnable = isWrite;
    management_byteSelect  = bs;
    management_address     = adr;
    management_writeData   = data;
    @(posedge clk); #1;
    management_enable      = 1'b0;
    management_writeEnable = 1'b0;
    management_byteSelect  = 4'h0;
    management_address     = 20'h0;
    management_writeData   = 32'h0;
  endtask

  // Slave response: wait, optionally answer for one edge, then wait for busy to fall.
  task automatic run_bus(input int waitCycles, input logic ack, input logic err,
                         input logic [31:0] data, output int busyCycles);
    int budget;
    busyCycles = 0;
    repeat (waitCycles) begin
      if (management_busy) busyCycles++;
      @(posedge clk); #1;
    end
    if (ack || err) begin
      wb.wb_ack_i  = ack;
      wb.wb_err_i  = err;
      wb.wb_data_i = data;
      if (management_busy) busyCycles++;
      @(posedge clk); #1;
      wb.wb_ack_i  = 1'b0;
      wb.wb_err_i  = 1'b0;
      wb.wb_data_i = 32'h0;
    end
    budget = 0;
    while (management_busy && budget < 40) begin
      busyCycles++;
      budget++;
      @(posedge clk); #1;
    end
    if (management_busy) begin
      checkCount++;
      $display("FAIL bus_wait: busy still %b after budget, required 0", management_busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checkCount++;
    if ({management_readData, management_busy, management_status, management_dropped} !== 36'h0)
      $display("FAIL reset_mgmt: got rd=%h busy=%b st=%0d drop=%b, required all 0",
               management_readData, management_busy, management_status, management_dropped);
    else passCount++;
    checkCount++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o, wb.wb_data_o} !== 39'h0)
      $display("FAIL reset_wb: got cyc=%b stb=%b we=%b sel=%h dat=%h, required 0",
               wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o, wb.wb_data_o);
    else passCount++;
    checkCount++;
    if (wb.wb_adr_o !== 32'h3000_0000)
      $display("FAIL reset_adr: got %h, required 30000000", wb.wb_adr_o);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_ok();
    int bc;
    exp_t e;
    issue(1'b0, 4'h0, 20'h00010, 32'h5555_5555);
    expQ.push_back('{rd: 32'hCAFE_F00D, st: STATUS_OK});
    checkCount++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o} !== 3'b110)
      $display("FAIL read_ctl: got cyc=%b stb=%b we=%b, required 1 1 0",
               wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o);
    else passCount++;
    checkCount++;
    if (wb.wb_adr_o !== 32'h3000_0040 || wb.wb_sel_o !== 4'hF || wb.wb_data_o !== 32'h0)
      $display("FAIL read_bus: got adr=%h sel=%h dat=%h, required 30000040 f 00000000",
               wb.wb_adr_o, wb.wb_sel_o, wb.wb_data_o);
    else passCount++;
    run_bus(2, 1'b1, 1'b0, 32'hCAFE_F00D, bc);
    checkCount++;
    if (bc !== 3) $display("FAIL read_busy_len: got %0d cycles, required 3", bc);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (management_readData !== e.rd || management_status !== e.st)
      $display("FAIL read_result: got rd=%h st=%0d, required rd=%h st=%0d",
               management_readData, management_status, e.rd, e.st);
    else passCount++;
    checkCount++;
    if (wb.wb_cyc_o !== 1'b0) $display("FAIL read_cyc_end: got %b, required 0", wb.wb_cyc_o);
    else passCount++;
  endtask

  task automatic test_write();
    int bc;
    exp_t e;
    issue(1'b1, 4'h3, 20'hFFFFF, 32'h1234_5678);
    expQ.push_back('{rd: 32'hCAFE_F00D, st: STATUS_OK});
    checkCount++;
    if (wb.wb_we_o !== 1'b1 || wb.wb_sel_o !== 4'h3 || wb.wb_adr_o !== 32'h303F_FFFC)
      $display("FAIL write_bus: got we=%b sel=%h adr=%h, required 1 3 303ffffc",
               wb.wb_we_o, wb.wb_sel_o, wb.wb_adr_o);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (wb.wb_data_o !== 32'h1234_5678 || wb.wb_cyc_o !== 1'b1)
      $display("FAIL write_data_stable: got dat=%h cyc=%b, required 12345678 1",
               wb.wb_data_o, wb.wb_cyc_o);
    else passCount++;
    run_bus(1, 1'b1, 1'b0, 32'hDEAD_0000, bc);
    e = expQ.pop_front();
    checkCount++;
    if (management_readData !== e.rd || management_status !== e.st)
      $display("FAIL write_result: got rd=%h st=%0d, required rd=%h st=%0d",
               management_readData, management_status, e.rd, e.st);
    else passCount++;
  endtask

  task automatic test_timeout();
    int bc;
    exp_t e;
    issue(1'b0, 4'h5, 20'h00123, 32'h0);
    expQ.push_back('{rd: 32'hFFFF_FFFF, st: STATUS_TIMEOUT});
    checkCount++;
    if (wb.wb_sel_o !== 4'h5) $display("FAIL timeout_sel: got %h, required 5", wb.wb_sel_o);
    else passCount++;
    run_bus(0, 1'b0, 1'b0, 32'h0, bc);
    checkCount++;
    if (bc !== 5) $display("FAIL timeout_len: got %0d bus cycles, required 5", bc);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (management_readData !== e.rd || management_status !== e.st || wb.wb_cyc_o !== 1'b0)
      $display("FAIL timeout_result: got rd=%h st=%0d cyc=%b, required rd=%h st=%0d cyc=0",
               management_readData, management_status, wb.wb_cyc_o, e.rd, e.st);
    else passCount++;
  endtask

  task automatic test_err_ack();
    int bc;
    exp_t e;
    issue(1'b0, 4'h0, 20'h00200, 32'h0);
    expQ.push_back('{rd: 32'hFFFF_FFFF, st: STATUS_BUS_ERROR});
    run_bus(1, 1'b1, 1'b1, 32'h1111_2222, bc);
    e = expQ.pop_front();
    checkCount++;
    if (management_readData !== e.rd || management_status !== e.st)
      $display("FAIL err_result: got rd=%h st=%0d, required rd=%h st=%0d",
               management_readData, management_status, e.rd, e.st);
    else passCount++;
    management_statusClear = 1'b1;
    @(posedge clk); #1;
    management_statusClear = 1'b0;
    checkCount++;
    if (management_status !== STATUS_OK || management_readData !== 32'hFFFF_FFFF)
      $display("FAIL err_clear: got st=%0d rd=%h, required st=0 rd=ffffffff",
               management_status, management_readData);
    else passCount++;
  endtask

  task automatic test_drop_clear();
    int bc;
    exp_t e;
    issue(1'b0, 4'h0, 20'h00ABC, 32'h0);
    expQ.push_back('{rd: 32'h0BAD_BEEF, st: STATUS_OK});
    issue(1'b1, 4'h1, 20'h55555, 32'hAAAA_AAAA);
    checkCount++;
    if (management_dropped !== 1'b1 || management_busy !== 1'b1)
      $display("FAIL drop_flag: got drop=%b busy=%b, required 1 1",
               management_dropped, management_busy);
    else passCount++;
    checkCount++;
    if (wb.wb_adr_o !== 32'h3000_2AF0 || wb.wb_we_o !== 1'b0 || wb.wb_data_o !== 32'h0)
      $display("FAIL drop_inflight: got adr=%h we=%b dat=%h, required 30002af0 0 00000000",
               wb.wb_adr_o, wb.wb_we_o, wb.wb_data_o);
    else passCount++;
    run_bus(0, 1'b1, 1'b0, 32'h0BAD_BEEF, bc);
    e = expQ.pop_front();
    checkCount++;
    if (management_readData !== e.rd || management_status !== e.st || management_dropped !== 1'b1)
      $display("FAIL drop_result: got rd=%h st=%0d drop=%b, required rd=%h st=%0d drop=1",
               management_readData, management_status, management_dropped, e.rd, e.st);
    else passCount++;
    management_statusClear = 1'b1;
    @(posedge clk); #1;
    management_statusClear = 1'b0;
    checkCount++;
    if (management_dropped !== 1'b0)
      $display("FAIL drop_clear: got drop=%b, required 0", management_dropped);
    else passCount++;
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b0, 4'h0, 20'h00040, 32'h0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || management_busy !== 1'b0)
      $display("FAIL rst_async: got cyc=%b stb=%b busy=%b, required 0 0 0",
               wb.wb_cyc_o, wb.wb_stb_o, management_busy);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (management_busy !== 1'b0 || management_readData !== 32'h0 ||
        management_status !== STATUS_OK || wb.wb_cyc_o !== 1'b0)
      $display("FAIL rst_after: got busy=%b rd=%h st=%0d cyc=%b, required 0 0 0 0",
               management_busy, management_readData, management_status, wb.wb_cyc_o);
    else passCount++;
  endtask

  initial begin
    wb.wb_ack_i  = 1'b0;
    wb.wb_err_i  = 1'b0;
    wb.wb_data_i = 32'h0;
    test_reset();
    test_read_ok();
    test_write();
    test_timeout();
    test_err_ack();
    test_drop_clear();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
